tt_um_serial_subtractor: RTL

Bit-serial 4-bit subtractor that computes A − B, the inverse operation of the team's combinational 4-bit ripple adder, over a start/busy/done handshake. It is a TinyTapeout user macro using the standard `tt_um_` pin set. Operands are on the dedicated inputs, and the registered difference is on the dedicated outputs. The block handles one bit per clock, LSB first, using a single borrow flop. It has a 4-cycle compute phase and holds its result until the next operation.

---
 rtl/tt_um_serial_subtractor.sv | 119 +++++++++++
 1 files changed

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial 4-bit subtractor (A - B), one bit per clock, LSB first, with a
// start/busy/done handshake on the standard TinyTapeout user-macro pins.
module tt_um_serial_subtractor (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] a_sr_q, a_sr_d;
  logic [3:0] b_sr_q, b_sr_d;
  logic [3:0] d_sr_q, d_sr_d;
  logic       bw_q, bw_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] res_d_q, res_d_d;
  logic       res_bw_q, res_bw_d;
  logic       res_z_q, res_z_d;

  logic       start_rise;
  logic       a0, b0, diff_bit, bw_next;
  logic [3:0] d_shifted;

  logic       unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      res_d_q  <= '0;
      res_bw_q <= 1'b0;
      res_z_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
      res_d_q  <= res_d_d;
      res_bw_q <= res_bw_d;
      res_z_q  <= res_z_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    d_sr_d     = d_sr_q;
    bw_d       = bw_q;
    cnt_d      = cnt_q;
    res_d_d    = res_d_q;
    res_bw_d   = res_bw_q;
    res_z_d    = res_z_q;

    start_rise = uio_in[0] & ~start_q;
    a0         = a_sr_q[0];
    b0         = b_sr_q[0];
    diff_bit   = a0 ^ b0 ^ bw_q;
    bw_next    = (~a0 & b0) | (~(a0 ^ b0) & bw_q);
    d_shifted  = {diff_bit, d_sr_q[3:1]};

    // ena low freezes everything, including the start edge detector.
    if (ena) begin
      start_d = uio_in[0];
      case (state_q)
        IDLE, DONE: begin
          if (start_rise) begin
            state_d = SHIFT;
            a_sr_d  = ui_in[3:0];
            b_sr_d  = ui_in[7:4];
            bw_d    = 1'b0;
            cnt_d   = '0;
            d_sr_d  = '0;
          end
        end
        SHIFT: begin
          d_sr_d = d_shifted;
          a_sr_d = {1'b0, a_sr_q[3:1]};
          b_sr_d = {1'b0, b_sr_q[3:1]};
          bw_d   = bw_next;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d  = DONE;
            res_d_d  = d_shifted;
            res_bw_d = bw_next;
            res_z_d  = (d_shifted == 4'd0) & ~bw_next;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign uo_out  = {2'b00, res_z_q, res_bw_q, res_d_q};
  assign uio_out = {5'b00000, (state_q == DONE), (state_q == SHIFT), 1'b0};
  assign uio_oe  = 8'b1111_1110;

endmodule
